// File: rtl/rob_commit_ctrl_if.sv
// Dispatcher, CDB, operand-query and commit/flush bundle of the reorder-buffer sequencer.
// The master side drives requests and broadcasts; the slave side is rob_commit_ctrl.
interface rob_commit_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             cdb_mispredict;

    logic [TAG_W-1:0] query_tag1;
    logic [TAG_W-1:0] query_tag2;
    logic             query_ready1;
    logic             query_ready2;
    logic [31:0]      query_data1;
    logic [31:0]      query_data2;

    logic             rf_commit_valid;
    logic [4:0]       rf_commit_dest;
    logic [TAG_W-1:0] rf_commit_tag;
    logic [31:0]      rf_commit_data;
    logic             rf_flush;
    logic             rob_empty;

    modport master (
        output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
               query_tag1, query_tag2,
        input  alloc_ready, alloc_tag, query_ready1, query_ready2, query_data1, query_data2,
               rf_commit_valid, rf_commit_dest, rf_commit_tag, rf_commit_data, rf_flush, rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
               query_tag1, query_tag2,
        output alloc_ready, alloc_tag, query_ready1, query_ready2, query_data1, query_data2,
               rf_commit_valid, rf_commit_dest, rf_commit_tag, rf_commit_data, rf_flush, rob_empty
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retire sequencer for the reorder buffer: allocates tags, captures CDB results, commits
// to the register file and flushes on a mispredicted retire. Optional macro: COMMIT_BYPASS_EN.
module rob_commit_ctrl #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    rob_commit_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
        return (tag != {TAG_W{1'b0}}) && (tag <= DEPTH_TAG);
    endfunction

    function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1));
    endfunction

    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(idx) + TAG_W'(1);
    endfunction

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            head_q, head_d;
    logic [IDX_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            ready_q, ready_d;
    logic [DEPTH-1:0]            mis_q, mis_d;
    logic [DEPTH-1:0][4:0]       rd_q, rd_d;
    logic [DEPTH-1:0][31:0]      data_q, data_d;
    logic                        commit_valid_q, commit_valid_d;
    logic [4:0]                  commit_dest_q, commit_dest_d;
    logic [TAG_W-1:0]            commit_tag_q, commit_tag_d;
    logic [31:0]                 commit_data_q, commit_data_d;
    logic                        flush_q, flush_d;

    logic                        alloc_ready_s;
    logic                        alloc_acc_s;
    logic [IDX_W-1:0]            cdb_idx_s;
    logic                        cdb_hit_s;
    logic [TAG_W-1:0]            head_tag_s;
    logic                        retire_s;
    logic                        retire_mis_s;
    logic [31:0]                 retire_data_s;
    logic [IDX_W-1:0]            q1_idx_s, q2_idx_s;

    // Decode CDB hit, retire decision and operand-query results from the current state.
    always_comb begin
        alloc_ready_s = (state_q == ST_RUN) && (count_q < DEPTH_CNT);
        alloc_acc_s   = bus.alloc_valid && alloc_ready_s;
        cdb_idx_s     = tag_to_idx(bus.cdb_tag);
        q1_idx_s      = tag_to_idx(bus.query_tag1);
        q2_idx_s      = tag_to_idx(bus.query_tag2);
        head_tag_s    = idx_to_tag(head_q);
        cdb_hit_s     = 1'b0;
        retire_s      = 1'b0;
        retire_mis_s  = mis_q[head_q];
        retire_data_s = data_q[head_q];
        bus.query_ready1 = 1'b0;
        bus.query_data1  = 32'h0000_0000;
        bus.query_ready2 = 1'b0;
        bus.query_data2  = 32'h0000_0000;

        if ((state_q == ST_RUN) && bus.cdb_valid && tag_in_range(bus.cdb_tag)) begin
            cdb_hit_s = valid_q[cdb_idx_s];
        end else begin
            cdb_hit_s = 1'b0;
        end

        if ((state_q == ST_RUN) && valid_q[head_q] && ready_q[head_q]) begin
            retire_s = 1'b1;
`ifdef COMMIT_BYPASS_EN
        end else if ((state_q == ST_RUN) && valid_q[head_q] && cdb_hit_s &&
                     (bus.cdb_tag == head_tag_s) && !bus.cdb_mispredict) begin
            retire_s      = 1'b1;
            retire_mis_s  = 1'b0;
            retire_data_s = bus.cdb_data;
`endif
        end else begin
            retire_s = 1'b0;
        end

        // A registered result wins; otherwise a same-cycle broadcast is forwarded.
        if (tag_in_range(bus.query_tag1) && valid_q[q1_idx_s] && ready_q[q1_idx_s]) begin
            bus.query_ready1 = 1'b1;
            bus.query_data1  = data_q[q1_idx_s];
        end else if (cdb_hit_s && (bus.cdb_tag == bus.query_tag1)) begin
            bus.query_ready1 = 1'b1;
            bus.query_data1  = bus.cdb_data;
        end else begin
            bus.query_ready1 = 1'b0;
        end

        if (tag_in_range(bus.query_tag2) && valid_q[q2_idx_s] && ready_q[q2_idx_s]) begin
            bus.query_ready2 = 1'b1;
            bus.query_data2  = data_q[q2_idx_s];
        end else if (cdb_hit_s && (bus.cdb_tag == bus.query_tag2)) begin
            bus.query_ready2 = 1'b1;
            bus.query_data2  = bus.cdb_data;
        end else begin
            bus.query_ready2 = 1'b0;
        end
    end

    // Next-state: allocate at tail, capture CDB, retire head, flush on mispredicted retire.
    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        valid_d        = valid_q;
        ready_d        = ready_q;
        mis_d          = mis_q;
        rd_d           = rd_q;
        data_d         = data_q;
        commit_valid_d = commit_valid_q;
        commit_dest_d  = commit_dest_q;
        commit_tag_d   = commit_tag_q;
        commit_data_d  = commit_data_q;
        flush_d        = flush_q;

        if (rdy) begin
            commit_valid_d = 1'b0;
            flush_d        = 1'b0;

            if (alloc_acc_s) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                mis_d[tail_q]   = 1'b0;
                rd_d[tail_q]    = bus.alloc_rd;
                tail_d          = tail_q + IDX_W'(1);
            end else begin
                tail_d = tail_q;
            end

            if (cdb_hit_s) begin
                ready_d[cdb_idx_s] = 1'b1;
                data_d[cdb_idx_s]  = bus.cdb_data;
                mis_d[cdb_idx_s]   = bus.cdb_mispredict;
            end else begin
                data_d = data_q;
            end

            if (retire_s) begin
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + IDX_W'(1);
                commit_valid_d  = 1'b1;
                commit_dest_d   = rd_q[head_q];
                commit_tag_d    = head_tag_s;
                commit_data_d   = retire_data_s;
            end else begin
                head_d = head_q;
            end

            case ({alloc_acc_s, retire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Everything younger than a mispredicted retire is wrong-path work.
            if (retire_s && retire_mis_s) begin
                valid_d = {DEPTH{1'b0}};
                ready_d = {DEPTH{1'b0}};
                mis_d   = {DEPTH{1'b0}};
                head_d  = {IDX_W{1'b0}};
                tail_d  = {IDX_W{1'b0}};
                count_d = {CNT_W{1'b0}};
                state_d = ST_FLUSH;
            end else if (state_q == ST_FLUSH) begin
                flush_d = 1'b1;
                state_d = ST_RUN;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            head_q         <= {IDX_W{1'b0}};
            tail_q         <= {IDX_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            valid_q        <= {DEPTH{1'b0}};
            ready_q        <= {DEPTH{1'b0}};
            mis_q          <= {DEPTH{1'b0}};
            rd_q           <= {(DEPTH*5){1'b0}};
            data_q         <= {(DEPTH*32){1'b0}};
            commit_valid_q <= 1'b0;
            commit_dest_q  <= 5'd0;
            commit_tag_q   <= {TAG_W{1'b0}};
            commit_data_q  <= 32'h0000_0000;
            flush_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            mis_q          <= mis_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            commit_valid_q <= commit_valid_d;
            commit_dest_q  <= commit_dest_d;
            commit_tag_q   <= commit_tag_d;
            commit_data_q  <= commit_data_d;
            flush_q        <= flush_d;
        end
    end

    // While frozen a pending pulse is held back, so it shows exactly once after rdy returns.
    assign bus.alloc_ready     = alloc_ready_s;
    assign bus.alloc_tag       = idx_to_tag(tail_q);
    assign bus.rob_empty       = (count_q == {CNT_W{1'b0}});
    assign bus.rf_commit_valid = commit_valid_q & rdy;
    assign bus.rf_commit_dest  = commit_dest_q;
    assign bus.rf_commit_tag   = commit_tag_q;
    assign bus.rf_commit_data  = commit_data_q;
    assign bus.rf_flush        = flush_q & rdy;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl (default build): allocation, wrap, in-order retire,
// mispredict flush, query forwarding, rdy freeze and asynchronous reset.
module tb_rob_commit_ctrl;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    rob_commit_ctrl_if #(.TAG_W(TAG_W)) bus ();

    rob_commit_ctrl #(.DEPTH(16), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_commit(input string tag, input logic v, input logic [4:0] dest,
                              input logic [TAG_W-1:0] t, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(bus.rf_commit_valid), 32'(v));
        if (v) begin
            chk({tag, "_dest"}, 32'(bus.rf_commit_dest), 32'(dest));
            chk({tag, "_tag"},  32'(bus.rf_commit_tag),  32'(t));
            chk({tag, "_data"}, bus.rf_commit_data, data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy                = 1'b1;
        bus.alloc_valid    = 1'b0;
        bus.alloc_rd       = 5'd0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = 5'd0;
        bus.cdb_data       = 32'h0;
        bus.cdb_mispredict = 1'b0;
        bus.query_tag1     = 5'd0;
        bus.query_tag2     = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic alloc_one(input logic [4:0] rd);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = rd;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic cdb_one(input logic [4:0] tag, input logic [31:0] data, input logic mis);
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = tag;
        bus.cdb_data       = data;
        bus.cdb_mispredict = mis;
        tick();
        bus.cdb_valid      = 1'b0;
        bus.cdb_mispredict = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #3;
        chk("rst_commit", 32'(bus.rf_commit_valid), 32'd0);
        chk("rst_flush",  32'(bus.rf_flush),        32'd0);
        chk("rst_empty",  32'(bus.rob_empty),       32'd1);
        chk("rst_tag",    32'(bus.alloc_tag),       32'd1);
        rst = 1'b0;
        tick();

        // Single instruction: alloc, broadcast, commit two edges later
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd5;
        #1;
        chk("t1_ready", 32'(bus.alloc_ready), 32'd1);
        chk("t1_tag",   32'(bus.alloc_tag),   32'd1);
        tick();
        bus.alloc_valid = 1'b0;
        chk("t1_not_empty", 32'(bus.rob_empty), 32'd0);
        cdb_one(5'd1, 32'hDEAD_BEEF, 1'b0);
        chk_commit("t1_early", 1'b0, 5'd0, 5'd0, 32'h0);
        tick();
        chk_commit("t1_commit", 1'b1, 5'd5, 5'd1, 32'hDEAD_BEEF);
        tick();
        chk_commit("t1_after", 1'b0, 5'd0, 5'd0, 32'h0);
        chk("t1_empty", 32'(bus.rob_empty), 32'd1);

        // Fill all 16 entries, then retire the head and see the tag wrap to 1
        do_reset();
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = 5'(i);
            #1;
            chk("t2_alloc_tag", 32'(bus.alloc_tag), 32'(i + 1));
            tick();
        end
        bus.alloc_rd = 5'd31;
        #1;
        chk("t2_full_ready", 32'(bus.alloc_ready), 32'd0);
        chk("t2_full_empty", 32'(bus.rob_empty),   32'd0);
        cdb_one(5'd1, 32'h0000_0111, 1'b0);
        chk("t2_still_full", 32'(bus.alloc_ready), 32'd0);
        tick();
        bus.alloc_valid = 1'b0;
        chk_commit("t2_commit", 1'b1, 5'd0, 5'd1, 32'h0000_0111);
        chk("t2_ready_again", 32'(bus.alloc_ready), 32'd1);
        chk("t2_wrap_tag",    32'(bus.alloc_tag),   32'd1);

        // Out-of-order results retire in program order on consecutive cycles
        do_reset();
        tick();
        alloc_one(5'd1);
        alloc_one(5'd2);
        alloc_one(5'd3);
        cdb_one(5'd3, 32'h0000_0033, 1'b0);
        cdb_one(5'd2, 32'h0000_0022, 1'b0);
        cdb_one(5'd1, 32'h0000_0011, 1'b0);
        chk_commit("t3_none", 1'b0, 5'd0, 5'd0, 32'h0);
        tick();
        chk_commit("t3_c1", 1'b1, 5'd1, 5'd1, 32'h0000_0011);
        tick();
        chk_commit("t3_c2", 1'b1, 5'd2, 5'd2, 32'h0000_0022);
        tick();
        chk_commit("t3_c3", 1'b1, 5'd3, 5'd3, 32'h0000_0033);
        tick();
        chk_commit("t3_done", 1'b0, 5'd0, 5'd0, 32'h0);
        chk("t3_empty", 32'(bus.rob_empty), 32'd1);

        // Mispredicted head commits, then flush; the younger entry never commits
        do_reset();
        tick();
        alloc_one(5'd1);
        alloc_one(5'd2);
        cdb_one(5'd1, 32'h0000_000A, 1'b1);
        cdb_one(5'd2, 32'h0000_000B, 1'b0);
        chk_commit("t4_commit", 1'b1, 5'd1, 5'd1, 32'h0000_000A);
        chk("t4_no_flush_yet", 32'(bus.rf_flush),    32'd0);
        chk("t4_flush_busy",   32'(bus.alloc_ready), 32'd0);
        chk("t4_empty",        32'(bus.rob_empty),   32'd1);
        tick();
        chk("t4_flush",   32'(bus.rf_flush), 32'd1);
        chk_commit("t4_no_commit_w_flush", 1'b0, 5'd0, 5'd0, 32'h0);
        chk("t4_ready",   32'(bus.alloc_ready), 32'd1);
        chk("t4_tag",     32'(bus.alloc_tag),   32'd1);
        tick();
        chk("t4_flush_end", 32'(bus.rf_flush), 32'd0);
        chk_commit("t4_tag2_never", 1'b0, 5'd0, 5'd0, 32'h0);
        tick();
        chk_commit("t4_tag2_never2", 1'b0, 5'd0, 5'd0, 32'h0);

        // Query forwarding from the same-cycle CDB and from the stored entry
        do_reset();
        tick();
        alloc_one(5'd1);
        alloc_one(5'd2);
        bus.query_tag1     = 5'd0;
        bus.query_tag2     = 5'd2;
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = 5'd2;
        bus.cdb_data       = 32'h0000_0055;
        #1;
        chk("t5_fwd_ready", 32'(bus.query_ready2), 32'd1);
        chk("t5_fwd_data",  bus.query_data2,       32'h0000_0055);
        chk("t5_tag0_ready", 32'(bus.query_ready1), 32'd0);
        chk("t5_tag0_data",  bus.query_data1,       32'h0);
        tick();
        bus.cdb_valid  = 1'b0;
        bus.query_tag1 = 5'd1;
        #1;
        chk("t5_stored_ready", 32'(bus.query_ready2), 32'd1);
        chk("t5_stored_data",  bus.query_data2,       32'h0000_0055);
        chk("t5_pending",      32'(bus.query_ready1), 32'd0);

        // rdy low freezes a ready head; the commit happens once rdy returns
        do_reset();
        tick();
        alloc_one(5'd7);
        cdb_one(5'd1, 32'h0000_0077, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_commit("t6_frozen", 1'b0, 5'd0, 5'd0, 32'h0);
        end
        rdy = 1'b1;
        tick();
        chk_commit("t6_commit", 1'b1, 5'd7, 5'd1, 32'h0000_0077);
        tick();
        chk_commit("t6_after", 1'b0, 5'd0, 5'd0, 32'h0);

        // Asynchronous reset while a commit pulse is showing
        alloc_one(5'd9);
        cdb_one(5'd2, 32'h0000_0099, 1'b0);
        tick();
        chk_commit("t7_pre", 1'b1, 5'd9, 5'd2, 32'h0000_0099);
        rst = 1'b1;
        #1;
        chk("t7_commit", 32'(bus.rf_commit_valid), 32'd0);
        chk("t7_dest",   32'(bus.rf_commit_dest),  32'd0);
        chk("t7_data",   bus.rf_commit_data,       32'h0);
        chk("t7_empty",  32'(bus.rob_empty),       32'd1);
        chk("t7_tag",    32'(bus.alloc_tag),       32'd1);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder-buffer sequencer that allocates rename tags for the dispatcher and collects results from the CDB.
- Retires entries in program order into the architectural register file's single write/commit port.
- Owns the register file's flush line: on a mispredicted retire it clears the buffer and pulses flush.
- Tag convention matches the register file: tag 0 means "no dependency"; entry index i carries tag i+1.

Parameters:
DEPTH, 16, number of ROB entries; power of two, at most 31.
TAG_W, 5, width of rename tag; tags range 1..DEPTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; when low all state freezes
alloc_valid  in  1  dispatcher requests an entry this cycle
alloc_rd  in  5  destination register of the allocated instruction (0 = none)
alloc_ready  out  1  entry available (combinational)
alloc_tag  out  TAG_W  tag given to the request (combinational, tail+1)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  tag of broadcast result
cdb_data  in  32  result value
cdb_mispredict  in  1  broadcasting instruction was a mispredicted branch/jump
query_tag1  in  TAG_W  operand-1 tag lookup
query_tag2  in  TAG_W  operand-2 tag lookup
query_ready1  out  1  tag1 result available (combinational)
query_ready2  out  1  tag2 result available (combinational)
query_data1  out  32  tag1 value
query_data2  out  32  tag2 value
rf_commit_valid  out  1  retire pulse to register file
rf_commit_dest  out  5  retired rd
rf_commit_tag  out  TAG_W  retired tag
rf_commit_data  out  32  retired value
rf_flush  out  1  one-cycle flush pulse to register file and all units
rob_empty  out  1  count==0

Behaviour:
- Reset (async): head=tail=count=0; all entries invalid; state RUN; all registered outputs 0.
- rdy=0: no state change; rf_commit_valid and rf_flush drive 0.
- Entry fields: valid, ready, mispredict, rd[4:0], data[31:0].
- alloc_ready = (state==RUN) && count<DEPTH.
  - On an accepting edge (alloc_valid&&alloc_ready&&rdy): entry[tail] <= {valid=1, ready=0, mispredict=0, rd=alloc_rd}; tail <= tail+1 mod DEPTH.
- CDB: on edge with cdb_valid, if entry[cdb_tag-1] is valid, set ready=1, data=cdb_data, mispredict=cdb_mispredict.
  - A CDB tag of 0 or one naming an invalid entry is ignored.
- Query: ready/data come from entry[tag-1] if valid&&ready, else from the same-cycle CDB match.
  - Tag 0 returns ready=0, data=0.
- Retire (RUN state, head entry valid&&ready at edge E): pop head.
  - head <= head+1.
  - Registered outputs after E: rf_commit_valid=1 for exactly one cycle, with dest/tag/data of the popped entry.
  - At most one retire per cycle.
  - Latency: CDB at edge E0 -> commit pulse visible after edge E0+1.
- count: +1 on alloc only, -1 on retire only, unchanged when both occur on the same edge.
  - Alloc into a full buffer is impossible (alloc_ready=0), including when a retire happens that same cycle.
- Mispredict retire: popped head has mispredict=1 → commit pulse issued as normal.
  - At the same edge all entries are invalidated, head=tail=count=0, and state moves to FLUSH.
- FLUSH (one cycle): alloc_ready=0, CDB ignored; at the next edge rf_flush=1 for one cycle, state returns to RUN.
  - The commit pulse and the flush pulse are never asserted in the same cycle.
- Wrap-around: head and tail wrap modulo DEPTH; tag = index+1, so tags run 1..DEPTH repeatedly.
- rf_commit_valid is asserted even when rd=0; the register file ignores the write.

Optional Feature:
COMMIT_BYPASS_EN
- Defined: if the head is valid and not ready, and cdb_valid targets the head tag without mispredict, the head retires at that same edge using cdb_data.
  - CDB-to-commit latency drops to 1 edge.
  - A mispredicting CDB still takes the normal path.
- Undefined: a retire requires the head ready bit to already be registered (2-edge latency).

Test Plan:
- Reset then alloc rd=5 → alloc_tag=1; CDB tag1 data 0xDEADBEEF → after 2 edges rf_commit_valid=1, dest=5, tag=1, data=0xDEADBEEF; rob_empty=1 the cycle after.
- Alloc 16 entries with no CDB → alloc_ready=0, count=16. CDB tag1 → head retires; next cycle alloc_ready=1 and alloc_tag=1 (wrap).
- Alloc tags 1,2,3; CDB order 3,2,1 → commits appear in tag order 1,2,3 on consecutive cycles.
- Alloc tags 1,2; CDB tag1 mispredict=1, CDB tag2 → tag1 commits, next cycle rf_flush=1; tag2 never commits; following alloc returns tag 1.
- Query tag2 in the same cycle as CDB tag2 data 0x55 → query_ready2=1, query_data2=0x55; query tag 0 → ready 0.
- rdy=0 for 3 cycles with a ready head → no commit pulse; commit occurs after rdy returns. Assert rst mid-operation → all outputs 0 immediately.
